// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential 16/8 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam int DIV_W_D   = 8;
  localparam int DIV_CNT_W = $clog2(DIV_W_D);

endpackage

// File: rtl/div_row_slice.sv
// One W+1-bit restoring-divider subtract row, x - y, ripple borrow.
// With DIV_APPROX_COLS_EN the low APPROX_COLS columns use approximate cells.
module div_row_slice #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 0
) (
  input  logic [W:0] i_x,
  input  logic [W:0] i_y,
  output logic [W:0] o_diff,
  output logic       o_bout
);

`ifdef DIV_APPROX_COLS_EN
  localparam bit APX_EN = 1'b1;
`else
  localparam bit APX_EN = 1'b0;
`endif

  logic [W+1:0] w_b;

  assign w_b[0] = 1'b0;

  for (genvar i = 0; i <= W; i++) begin : g_col
    if (APX_EN && (i < APPROX_COLS)) begin : g_apx
      assign o_diff[i] = ~w_b[i];
      assign w_b[i+1]  = ~i_x[i] & ~w_b[i];
    end else begin : g_ex
      assign o_diff[i] = i_x[i] ^ i_y[i] ^ w_b[i];
      assign w_b[i+1]  = (~i_x[i] & i_y[i])
                       | (~(i_x[i] ^ i_y[i]) & w_b[i]);
    end
  end

  assign o_bout = w_b[W+1];

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one subtract row reused for W_D cycles.
// Define DIV_APPROX_COLS_EN to build the low row columns from approximate cells.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int W_D         = DIV_W_D,
  parameter int APPROX_COLS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W_D-1:0] in_n,
  input  logic [W_D-1:0]   in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_D-1:0]   out_q,
  output logic [W_D-1:0]   out_r,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             busy
);

  localparam int W_N = 2 * W_D;
  localparam int CW  = $clog2(W_D);

  div_state_t     r_state;
  logic [W_D-1:0] r_rem;
  logic [W_D-1:0] r_low;
  logic [W_D-1:0] r_dreg;
  logic [W_D-1:0] r_q;
  logic [CW-1:0]  r_cnt;
  logic [W_D-1:0] r_out_q;
  logic [W_D-1:0] r_out_r;
  logic           r_dbz;
  logic           r_ovf;

  logic [W_D-1:0] w_n_hi;
  logic [W_D-1:0] w_n_lo;
  logic           w_dbz;
  logic           w_ovf;
  logic [W_D:0]   w_p;
  logic [W_D:0]   w_t;
  logic           w_bout;
  logic           w_qbit;
  logic [W_D-1:0] w_rem_nx;
  logic [W_D-1:0] w_q_nx;

  assign w_n_hi = in_n[W_N-1:W_D];
  assign w_n_lo = in_n[W_D-1:0];
  assign w_dbz  = (in_d == '0);
  assign w_ovf  = !w_dbz && (w_n_hi >= in_d);

  assign w_p = {r_rem, r_low[r_cnt]};

  div_row_slice #(
    .W           (W_D),
    .APPROX_COLS (APPROX_COLS)
  ) u_row (
    .i_x    (w_p),
    .i_y    ({1'b0, r_dreg}),
    .o_diff (w_t),
    .o_bout (w_bout)
  );

  // No borrow out of the MSB column means p >= divisor.
  assign w_qbit   = ~w_bout;
  assign w_rem_nx = w_qbit ? w_t[W_D-1:0] : w_p[W_D-1:0];
  assign w_q_nx   = {r_q[W_D-2:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_low   <= '0;
      r_dreg  <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_out_q <= '0;
      r_out_r <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            unique case (1'b1)
              w_dbz: begin
                r_dbz   <= 1'b1;
                r_out_q <= '1;
                r_out_r <= w_n_lo;
                r_state <= S_DONE;
              end
              w_ovf: begin
                r_ovf   <= 1'b1;
                r_out_q <= '1;
                r_out_r <= w_n_hi;
                r_state <= S_DONE;
              end
              default: begin
                r_rem   <= w_n_hi;
                r_low   <= w_n_lo;
                r_dreg  <= in_d;
                r_q     <= '0;
                r_cnt   <= CW'(W_D - 1);
                r_state <= S_RUN;
              end
            endcase
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          if (r_cnt == '0) begin
            r_out_q <= w_q_nx;
            r_out_r <= w_rem_nx;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_q     = r_out_q;
  assign out_r     = r_out_r;
  assign out_dbz   = r_dbz;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table, corner sequences,
// and randomized requests against a behavioural division model.
module tb_div_seq_ctrl;

  localparam int WD = 8;
  localparam int AC = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_n = '0;
  logic [7:0]  in_d = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_q;
  logic [7:0]  out_r;
  logic        out_dbz;
  logic        out_ovf;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  div_seq_ctrl #(
    .W_D         (WD),
    .APPROX_COLS (AC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division, or a column-level model of the
  // approximate row when the low columns are approximate.
  function automatic void ref_div(input logic [15:0] n, input logic [7:0] d,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dbz, output logic ovf);
    dbz = 1'b0;
    ovf = 1'b0;
    if (d == 0) begin
      dbz = 1'b1;
      q = 8'hFF;
      r = n[7:0];
    end else if (n[15:8] >= d) begin
      ovf = 1'b1;
      q = 8'hFF;
      r = n[15:8];
    end else begin
`ifdef DIV_APPROX_COLS_EN
      int rem;
      rem = int'(n[15:8]);
      q = '0;
      for (int i = 7; i >= 0; i--) begin
        int p, b, lowd, hp, hy, v, diff;
        logic qb;
        p = rem * 2 + int'(n[i]);
        b = 0;
        lowd = 0;
        for (int c = 0; c < AC; c++) begin
          lowd = lowd | ((b == 0 ? 1 : 0) << c);
          b = (((p >> c) & 1) == 0 && b == 0) ? 1 : 0;
        end
        hp = p >> AC;
        hy = int'(d) >> AC;
        v = hp - hy - b;
        qb = (v >= 0);
        diff = ((v & ((1 << (9 - AC)) - 1)) << AC) | lowd;
        q[i] = qb;
        rem = qb ? (diff & 255) : (p & 255);
      end
      r = rem[7:0];
`else
      q = 8'(n / d);
      r = 8'(n % d);
`endif
    end
  endfunction

  // Call at a negedge with the DUT idle; returns after the output handshake.
  task automatic run_txn(input logic [15:0] n, input logic [7:0] d,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dbz, output logic ovf,
                         output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_req", in_ready, 1);
    in_n = n;
    in_d = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = out_q;
    r = out_r;
    dbz = out_dbz;
    ovf = out_ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handshake",
          {in_ready, out_valid, out_dbz, out_ovf, busy}, 5'b10000);
  endtask

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] q, r, eq, er, sq, sr;
    logic dbz, ovf, edbz, eovf;
    int lat, seen;

    tbl[0] = '{16'd200,  8'd7,    8'd28,   8'd4,    1'b0, 1'b0, 8};
    tbl[1] = '{16'h1234, 8'h00,   8'hFF,   8'h34,   1'b1, 1'b0, 0};
    tbl[2] = '{16'h0A00, 8'h0A,   8'hFF,   8'h0A,   1'b0, 1'b1, 0};
    tbl[3] = '{16'h09FF, 8'h0A,   8'hFF,   8'h09,   1'b0, 1'b0, 8};
    tbl[4] = '{16'h00FF, 8'h01,   8'hFF,   8'h00,   1'b0, 1'b0, 8};
    tbl[5] = '{16'hFFFF, 8'hFF,   8'hFF,   8'hFF,   1'b0, 1'b1, 0};
    tbl[6] = '{16'hFEFF, 8'hFF,   8'hFF,   8'hFE,   1'b0, 1'b0, 8};
    tbl[7] = '{16'h0000, 8'h05,   8'h00,   8'h00,   1'b0, 1'b0, 8};
    tbl[8] = '{16'h0005, 8'h00,   8'hFF,   8'h05,   1'b1, 1'b0, 0};
    tbl[9] = '{16'd1000, 8'd9,    8'd111,  8'd1,    1'b0, 1'b0, 8};

    #1;
    check("reset_ready_valid_busy", {in_ready, out_valid, busy}, 3'b100);
    check("reset_q_r", {out_q, out_r}, 16'h0000);
    check("reset_flags", {out_dbz, out_ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].n, tbl[i].d, q, r, dbz, ovf, lat);
      eq = tbl[i].q;
      er = tbl[i].r;
`ifdef DIV_APPROX_COLS_EN
      ref_div(tbl[i].n, tbl[i].d, eq, er, edbz, eovf);
`endif
      check($sformatf("vec%0d_q", i), q, eq);
      check($sformatf("vec%0d_r", i), r, er);
      check($sformatf("vec%0d_flags", i), {dbz, ovf},
            {tbl[i].dbz, tbl[i].ovf});
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
    end

    // Back-pressure in DONE with a pending request that must not be taken.
    in_n = 16'd200;
    in_d = 8'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hold_latency", lat, 8);
    ref_div(16'd200, 8'd7, eq, er, edbz, eovf);
    check("hold_first_q_r", {out_q, out_r}, {eq, er});
    sq = out_q;
    sr = out_r;
    in_n = 16'h1234;
    in_d = 8'h00;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_ctl", k),
            {out_valid, in_ready, busy, out_dbz, out_ovf}, 5'b10100);
      check($sformatf("hold%0d_q_r", k), {out_q, out_r}, {sq, sr});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", {out_valid, in_ready, busy}, 3'b010);
    check("release_keeps_q_r", {out_q, out_r}, {sq, sr});
    @(negedge clk);
    in_valid = 1'b0;
    check("next_accept_dbz", {out_valid, out_dbz, out_ovf}, 3'b110);
    check("next_accept_q_r", {out_q, out_r}, 16'hFF34);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of an iteration.
    in_n = 16'd200;
    in_d = 8'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", {busy, out_valid}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctl", {in_ready, out_valid, busy}, 3'b100);
    check("async_reset_q_r", {out_q, out_r}, 16'h0000);
    check("async_reset_flags", {out_dbz, out_ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("no_result_after_reset", seen, 0);
    run_txn(16'd200, 8'd7, q, r, dbz, ovf, lat);
    check("post_reset_result", {q, r, dbz, ovf}, {eq, er, 2'b00});
    check("post_reset_latency", lat, 8);

    // Randomized requests against the reference model.
    for (int t = 0; t < 3000; t++) begin
      logic [15:0] n;
      logic [7:0] d, hi;
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) d = 8'h00;
      if (d != 0 && $urandom_range(0, 3) != 0)
        hi = 8'($urandom_range(0, int'(d) - 1));
      else
        hi = 8'($urandom_range(0, 255));
      n = {hi, 8'($urandom_range(0, 255))};
      ref_div(n, d, eq, er, edbz, eovf);
      run_txn(n, d, q, r, dbz, ovf, lat);
      check($sformatf("rand%0d_n%0h_d%0h", t, n, d),
            {q, r, dbz, ovf}, {eq, er, edbz, eovf});
      check($sformatf("rand%0d_latency", t), lat,
            (edbz || eovf) ? 0 : 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
